// File: rtl/regfile_scoreboard_pkg.sv
// Shared core package: register-file size defaults and the register-address type.
package regfile_scoreboard_pkg;

  localparam int XLEN_DEF  = 32;
  localparam int NREGS_DEF = 32;
  localparam int NRD_DEF   = 2;
  localparam int NWR_DEF   = 2;
  localparam int AW_DEF    = $clog2(NREGS_DEF);

  typedef logic [AW_DEF-1:0] reg_addr_t;

endpackage

// File: rtl/regfile_scoreboard_sb.sv
// Busy-bit scoreboard: tracks registers with an outstanding producer, gates issue,
// and keeps a registered population count of the busy bits.
module regfile_sb
  import regfile_scoreboard_pkg::*;
#(
  parameter  int NREGS = NREGS_DEF,
  parameter  int NRD   = NRD_DEF,
  parameter  int NWR   = NWR_DEF,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NRD-1:0][AW-1:0]  rd_addr_i,
  output logic [NRD-1:0]          rd_busy_o,
  input  logic [NWR-1:0]          wr_en_i,
  input  logic [NWR-1:0][AW-1:0]  wr_addr_i,
  input  logic                    iss_en_i,
  input  logic [AW-1:0]           iss_addr_i,
  output logic                    iss_ready_o,
  output logic [AW:0]             busy_cnt_o
);

  logic [NREGS-1:0] busy_q, busy_d, clr;
  logic [AW:0]      cnt_q, cnt_d;

  // Clears are applied before the ready check so a register being written back
  // this cycle can be re-reserved; the set then wins over the clear.
  always_comb begin
    clr = '0;
    for (int unsigned w = 0; w < NWR; w++) begin
      if (wr_en_i[w]) clr[wr_addr_i[w]] = 1'b1;
    end
    busy_d      = busy_q & ~clr;
    iss_ready_o = ~busy_d[iss_addr_i];
    if (iss_en_i && iss_ready_o) busy_d[iss_addr_i] = 1'b1;
    busy_d[0] = 1'b0;
    cnt_d = '0;
    for (int unsigned r = 0; r < NREGS; r++) begin
      cnt_d = cnt_d + {{AW{1'b0}}, busy_d[r]};
    end
    for (int unsigned i = 0; i < NRD; i++) begin
      rd_busy_o[i] = busy_q[rd_addr_i[i]] & ~clr[rd_addr_i[i]];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= '0;
      cnt_q  <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
    end
  end

  assign busy_cnt_o = cnt_q;

endmodule

// File: rtl/regfile_scoreboard.sv
// Multi-ported register file with write-to-read bypass and a busy-bit scoreboard.
module regfile_scoreboard
  import regfile_scoreboard_pkg::*;
#(
  parameter  int XLEN  = XLEN_DEF,
  parameter  int NREGS = NREGS_DEF,
  parameter  int NRD   = NRD_DEF,
  parameter  int NWR   = NWR_DEF,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NRD-1:0][AW-1:0]   rd_addr_i,
  output logic [NRD-1:0][XLEN-1:0] rd_data_o,
  output logic [NRD-1:0]           rd_busy_o,
  input  logic [NWR-1:0]           wr_en_i,
  input  logic [NWR-1:0][AW-1:0]   wr_addr_i,
  input  logic [NWR-1:0][XLEN-1:0] wr_data_i,
  input  logic                     iss_en_i,
  input  logic [AW-1:0]            iss_addr_i,
  output logic                     iss_ready_o,
  output logic [AW:0]              busy_cnt_o
);

  logic [XLEN-1:0] mem_q [NREGS];

  // Later ports are assigned last, so the highest-indexed writer wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned r = 0; r < NREGS; r++) mem_q[r] <= '0;
    end else begin
      for (int unsigned w = 0; w < NWR; w++) begin
        if (wr_en_i[w] && wr_addr_i[w] != '0) mem_q[wr_addr_i[w]] <= wr_data_i[w];
      end
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < NRD; i++) begin
      rd_data_o[i] = mem_q[rd_addr_i[i]];
      for (int unsigned w = 0; w < NWR; w++) begin
        if (wr_en_i[w] && wr_addr_i[w] == rd_addr_i[i]) rd_data_o[i] = wr_data_i[w];
      end
      if (rd_addr_i[i] == '0) rd_data_o[i] = '0;
    end
  end

  regfile_sb #(
    .NREGS (NREGS),
    .NRD   (NRD),
    .NWR   (NWR)
  ) u_sb (
    .clk         (clk),
    .rst_n       (rst_n),
    .rd_addr_i   (rd_addr_i),
    .rd_busy_o   (rd_busy_o),
    .wr_en_i     (wr_en_i),
    .wr_addr_i   (wr_addr_i),
    .iss_en_i    (iss_en_i),
    .iss_addr_i  (iss_addr_i),
    .iss_ready_o (iss_ready_o),
    .busy_cnt_o  (busy_cnt_o)
  );

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Scoreboard bench: driver pushes model-predicted outputs, a negedge monitor compares.
module tb_regfile_scoreboard;

  localparam int XLEN  = 32;
  localparam int NREGS = 32;
  localparam int NRD   = 2;
  localparam int NWR   = 2;
  localparam int AW    = 5;

  logic                     clk = 1'b0;
  logic                     rst_n;
  logic [NRD-1:0][AW-1:0]   rd_addr;
  logic [NRD-1:0][XLEN-1:0] rd_data;
  logic [NRD-1:0]           rd_busy;
  logic [NWR-1:0]           wr_en;
  logic [NWR-1:0][AW-1:0]   wr_addr;
  logic [NWR-1:0][XLEN-1:0] wr_data;
  logic                     iss_en;
  logic [AW-1:0]            iss_addr;
  logic                     iss_ready;
  logic [AW:0]              busy_cnt;

  regfile_scoreboard #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .NWR(NWR)) dut (
    .clk(clk), .rst_n(rst_n),
    .rd_addr_i(rd_addr), .rd_data_o(rd_data), .rd_busy_o(rd_busy),
    .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_data_i(wr_data),
    .iss_en_i(iss_en), .iss_addr_i(iss_addr), .iss_ready_o(iss_ready),
    .busy_cnt_o(busy_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [NRD-1:0][XLEN-1:0] d;
    logic [NRD-1:0]           b;
    logic                     rdy;
    logic [AW:0]              cnt;
  } exp_t;

  exp_t exp_q[$];
  logic vld = 1'b0;
  int   n_vec = 0;
  int   n_bad = 0;

  // Reference model: architectural contents and the set of reserved registers.
  logic [XLEN-1:0] m_regs [NREGS];
  bit              m_busy [NREGS];

  function automatic void model_reset();
    for (int r = 0; r < NREGS; r++) begin
      m_regs[r] = '0;
      m_busy[r] = 1'b0;
    end
  endfunction

  function automatic bit written(input logic [AW-1:0] a);
    for (int w = 0; w < NWR; w++) if (wr_en[w] && wr_addr[w] == a) return 1'b1;
    return 1'b0;
  endfunction

  function automatic exp_t predict();
    exp_t e;
    int   c = 0;
    for (int i = 0; i < NRD; i++) begin
      logic [AW-1:0] a = rd_addr[i];
      e.d[i] = (a == 0) ? '0 : m_regs[a];
      if (a != 0) for (int w = 0; w < NWR; w++) if (wr_en[w] && wr_addr[w] == a) e.d[i] = wr_data[w];
      e.b[i] = m_busy[a] && !written(a);
    end
    e.rdy = !(m_busy[iss_addr] && !written(iss_addr));
    for (int r = 0; r < NREGS; r++) c += int'(m_busy[r]);
    e.cnt = c[AW:0];
    return e;
  endfunction

  function automatic void model_edge(input bit rdy);
    for (int w = 0; w < NWR; w++) begin
      if (wr_en[w] && wr_addr[w] != 0) m_regs[wr_addr[w]] = wr_data[w];
      if (wr_en[w]) m_busy[wr_addr[w]] = 1'b0;
    end
    if (iss_en && rdy && iss_addr != 0) m_busy[iss_addr] = 1'b1;
  endfunction

  task automatic apply(input logic [NRD-1:0][AW-1:0] ra, input logic [NWR-1:0] we,
                       input logic [NWR-1:0][AW-1:0] wa, input logic [NWR-1:0][XLEN-1:0] wd,
                       input logic ie, input logic [AW-1:0] ia);
    exp_t e;
    @(posedge clk);
    #1;
    rd_addr = ra; wr_en = we; wr_addr = wa; wr_data = wd; iss_en = ie; iss_addr = ia;
    e = predict();
    exp_q.push_back(e);
    vld = 1'b1;
    model_edge(e.rdy);
  endtask

  task automatic zero_inputs();
    rd_addr = '0; wr_en = '0; wr_addr = '0; wr_data = '0; iss_en = 1'b0; iss_addr = '0;
  endtask

  // Reset pulse between edges: outputs must clear while rst_n is still low.
  task automatic reset_pulse();
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    zero_inputs();
    model_reset();
    exp_q.push_back(predict());
    vld = 1'b1;
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    vld   = 1'b0;
  endtask

  always @(negedge clk) begin
    if (vld) begin
      exp_t e;
      if (exp_q.size() == 0) begin
        n_vec++; n_bad++;
        $display("FAIL underflow: monitor saw output with no expectation queued");
      end else begin
        e = exp_q.pop_front();
        n_vec++;
        if (rd_data !== e.d) begin
          n_bad++;
          $display("FAIL rd_data: got %h want %h (addr %h)", rd_data, e.d, rd_addr);
        end
        if (rd_busy !== e.b) begin
          n_bad++;
          $display("FAIL rd_busy: got %b want %b (addr %h)", rd_busy, e.b, rd_addr);
        end
        if (iss_ready !== e.rdy) begin
          n_bad++;
          $display("FAIL iss_ready: got %b want %b (iss_addr %0d)", iss_ready, e.rdy, iss_addr);
        end
        if (busy_cnt !== e.cnt) begin
          n_bad++;
          $display("FAIL busy_cnt: got %0d want %0d", busy_cnt, e.cnt);
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [NRD-1:0][AW-1:0]   ra;
    logic [NWR-1:0]           we;
    logic [NWR-1:0][AW-1:0]   wa;
    logic [NWR-1:0][XLEN-1:0] wd;

    rst_n = 1'b0;
    zero_inputs();
    model_reset();
    exp_q.push_back(predict());
    vld = 1'b1;
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    vld   = 1'b0;

    // Every address reads zero and idle after reset.
    for (int i = 0; i < NREGS; i += 2)
      apply({AW'(i + 1), AW'(i)}, 2'b00, '0, '0, 1'b0, AW'(i));

    // Bypass on write, then stored value; writes to x0 ignored.
    apply({5'd0, 5'd5}, 2'b01, {5'd0, 5'd5}, {32'h0, 32'hDEADBEEF}, 1'b0, 5'd0);
    apply({5'd0, 5'd5}, 2'b00, '0, '0, 1'b0, 5'd0);
    apply({5'd5, 5'd0}, 2'b01, {5'd0, 5'd0}, {32'h0, 32'h1234}, 1'b0, 5'd0);
    apply({5'd5, 5'd0}, 2'b00, '0, '0, 1'b1, 5'd0);

    // Both ports write x7: port 1 wins.
    apply({5'd7, 5'd7}, 2'b11, {5'd7, 5'd7}, {32'h22, 32'h11}, 1'b0, 5'd0);
    apply({5'd0, 5'd7}, 2'b00, '0, '0, 1'b0, 5'd0);

    // Issue x3, re-issue ignored, write-back clears.
    apply({5'd0, 5'd3}, 2'b00, '0, '0, 1'b1, 5'd3);
    apply({5'd0, 5'd3}, 2'b00, '0, '0, 1'b1, 5'd3);
    apply({5'd0, 5'd3}, 2'b10, {5'd3, 5'd0}, {32'hCAFE0003, 32'h0}, 1'b0, 5'd3);
    apply({5'd0, 5'd3}, 2'b00, '0, '0, 1'b0, 5'd3);

    // Write-back and re-issue of busy x3 in one cycle.
    apply({5'd0, 5'd3}, 2'b00, '0, '0, 1'b1, 5'd3);
    apply({5'd0, 5'd3}, 2'b01, {5'd0, 5'd3}, {32'h0, 32'hBEEF0003}, 1'b1, 5'd3);
    apply({5'd0, 5'd3}, 2'b00, '0, '0, 1'b0, 5'd3);

    // Randomized traffic concentrated on a few registers to force collisions.
    for (int n = 0; n < 3000; n++) begin
      for (int i = 0; i < NRD; i++)
        ra[i] = ($urandom_range(0, 3) == 0) ? AW'($urandom) : AW'($urandom_range(0, 7));
      for (int w = 0; w < NWR; w++) begin
        wa[w] = ($urandom_range(0, 3) == 0) ? AW'($urandom) : AW'($urandom_range(0, 7));
        wd[w] = $urandom;
      end
      we = NWR'($urandom);
      apply(ra, we, wa, wd, 1'($urandom), ($urandom_range(0, 3) == 0) ? AW'($urandom) : AW'($urandom_range(0, 7)));
    end

    // Drain all reservations, then fill every register and reset mid-cycle.
    for (int r = 1; r < NREGS; r += 2)
      apply('0, 2'b11, {AW'(r + 1), AW'(r)}, {32'(r + 1), 32'(r)}, 1'b0, '0);
    for (int r = 1; r < NREGS; r++)
      apply({AW'(r), AW'(r - 1)}, 2'b00, '0, '0, 1'b1, AW'(r));
    apply({5'd31, 5'd1}, 2'b00, '0, '0, 1'b0, 5'd9);
    reset_pulse();
    apply({5'd31, 5'd1}, 2'b00, '0, '0, 1'b0, 5'd1);

    @(posedge clk);
    #1;
    vld = 1'b0;
    zero_inputs();
    @(negedge clk);
    n_vec++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d expectations left want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/regfile_scoreboard.md
REGFILE_SCOREBOARD -- requirements
Module: regfile_scoreboard

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
- XLEN, 32, data width
- NREGS, 32, architectural register count (power of two, >= 2)
- NRD, 2, read ports
- NWR, 2, write ports
- AW, $clog2(NREGS), derived address width, not overridable
REQ-002 Ports SHALL be (name, direction, width, meaning):
- clk, in, 1, the single clock
- rst_n, in, 1, asynchronous active-low reset
- rd_addr_i, in, NRD x AW, read addresses
- rd_data_o, out, NRD x XLEN, read data
- rd_busy_o, out, NRD, addressed register has a pending producer
- wr_en_i, in, NWR, write-back strobes
- wr_addr_i, in, NWR x AW, write-back addresses
- wr_data_i, in, NWR x XLEN, write-back data
- iss_en_i, in, 1, issue request reserving a destination
- iss_addr_i, in, AW, destination being reserved
- iss_ready_o, out, 1, issue can be accepted this cycle
- busy_cnt_o, out, AW+1, number of currently reserved registers

Function
REQ-003 Writes SHALL commit on the rising edge of clk (not the falling edge).
REQ-004 Register 0 SHALL read as zero, ignore writes, and never be busy; issue to address 0 SHALL be accepted with no state change.
REQ-005 Reads SHALL be combinational, with zero-cycle latency.
REQ-006 When a write port targets a read address in the same cycle (wr_en_i set, address non-zero), the read SHALL return the write data (bypass).
REQ-007 If more than one write port targets the same address in one cycle, the highest-indexed port SHALL win, for both storage and bypass.
REQ-008 Scoreboard: one busy bit per register.
- Accepted issue (iss_en_i && iss_ready_o) sets busy[iss_addr_i] at the next edge.
- A write to a busy register clears its bit at the next edge.
REQ-009 iss_ready_o SHALL equal !busy[iss_addr_i] after same-cycle write clears are applied, so issue to a register being written back this cycle is accepted (WAW prevention).
REQ-010 If the same address is issued and written in one cycle, the set SHALL take priority: data is written and busy ends up set.
REQ-011 A write to a non-busy register SHALL update data and leave busy clear.
REQ-012 rd_busy_o[i] SHALL reflect the registered busy bit, masked to 0 when a write to that address occurs in the same cycle (consistent with bypass).
REQ-013 busy_cnt_o SHALL be registered and equal the population count of the busy bits, updated in the same edge as the bits; maximum NREGS-1.
REQ-014 iss_en_i while iss_ready_o is low SHALL have no effect; the requester holds the request.

Reset
REQ-015 While rst_n is low, asynchronously: all registers SHALL be 0, all busy bits 0, and busy_cnt_o 0.
REQ-016 After rst_n deasserts, iss_ready_o SHALL be 1 and all reads SHALL return 0.
REQ-017 Reset asserted mid-operation SHALL discard pending reservations and same-cycle writes.

Structure
REQ-018 Defaults of XLEN, NREGS, NRD and NWR SHALL live in the shared core package, alongside the register-address typedef.
REQ-019 The scoreboard (busy bits, ready, count) SHALL be a sub-module, regfile_sb, instantiated once.
REQ-020 Storage SHALL be a flop array without a read-enable, suitable for FPGA LUT-RAM or flops.

Verification
REQ-021 Reset, then read every address -> all 0, busy 0, busy_cnt_o=0, iss_ready_o=1.
REQ-022 Write x5=0xDEADBEEF with rd_addr_i[0]=5 in the same cycle -> rd_data_o[0]=0xDEADBEEF that cycle and after; write x0=0x1234 -> x0 still reads 0.
REQ-023 Ports 0 and 1 both write x7 (0x11, 0x22) -> x7=0x22 and bypass shows 0x22.
REQ-024 Issue x3 -> next cycle busy_cnt_o=1, rd_busy_o=1, iss_ready_o=0 for x3; second issue of x3 is ignored; write x3 -> busy clears and count returns to 0.
REQ-025 Busy x3 written back and re-issued in one cycle -> iss_ready_o=1, x3 holds the new data, busy stays set, count unchanged.
REQ-026 Issue x1..x31 then pulse rst_n low between edges -> outputs clear immediately and count=0.
